pooling_ctrl_pipe: RTL and testbench

POOLING_CTRL_PIPE -- requirements
Module: pooling_ctrl_pipe

---
 rtl/pooling_ctrl_pipe.sv | 109 ++++++++++
 tb/tb_pooling_ctrl_pipe.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/pooling_ctrl_pipe.sv
// Elastic pipeline carrying pooling buffer addresses and control bits.
// Empty stages absorb data while downstream stalls, so bubbles collapse.
module pooling_ctrl_pipe #(
    parameter int ADDR_W = 4,
    parameter int STAGES = 3,
    parameter int CNT_W  = $clog2(STAGES + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_adrs,
    input  logic [ADDR_W-1:0] in_adrs_out,
    input  logic              in_mux_en,
    input  logic              in_wr_ctrl1,
    input  logic              in_wr_ctrl2,
    input  logic              in_pool_done,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_adrs,
    output logic [ADDR_W-1:0] out_adrs_out,
    output logic              out_mux_en,
    output logic              out_wr_ctrl1,
    output logic              out_wr_ctrl2,
    output logic              out_pool_done,
    output logic [CNT_W-1:0]  occupancy,
    output logic              done_pulse
);

    localparam int PW = 2 * ADDR_W + 4;
    typedef logic [PW-1:0] payload_t;

    logic [STAGES-1:0] valid_q, valid_d;
    payload_t          data_q [STAGES];
    payload_t          data_d [STAGES];
    logic [CNT_W-1:0]  occ_q, occ_d;
    logic [STAGES-1:0] load;
    logic              out_xfer;
    logic              in_xfer;
    logic              adv;
    payload_t          in_pl;

    assign in_pl = {in_adrs, in_adrs_out, in_mux_en, in_wr_ctrl1, in_wr_ctrl2, in_pool_done};

    always_comb begin
        out_xfer = valid_q[STAGES-1] && out_ready;
        // A stage loads when any stage at or beyond it has room this cycle.
        adv = out_xfer;
        load = '0;
        for (int i = STAGES - 1; i >= 0; i--) begin
            adv     = adv || !valid_q[i];
            load[i] = adv;
        end
        in_ready = !rst && !flush && load[0];
        in_xfer  = in_valid && in_ready;
    end

    always_comb begin
        valid_d = valid_q;
        for (int i = 0; i < STAGES; i++) begin
            data_d[i] = data_q[i];
        end
        if (load[0]) begin
            valid_d[0] = in_xfer;
            data_d[0]  = in_pl;
        end
        for (int i = 1; i < STAGES; i++) begin
            if (load[i]) begin
                valid_d[i] = valid_q[i-1];
                data_d[i]  = data_q[i-1];
            end
        end
        // Flush drops entries but leaves payload registers untouched.
        if (flush) begin
            valid_d = '0;
            for (int i = 0; i < STAGES; i++) begin
                data_d[i] = data_q[i];
            end
        end
        occ_d = '0;
        for (int i = 0; i < STAGES; i++) begin
            occ_d = occ_d + CNT_W'(valid_d[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            occ_q   <= '0;
            for (int i = 0; i < STAGES; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            occ_q   <= occ_d;
            for (int i = 0; i < STAGES; i++) begin
                data_q[i] <= data_d[i];
            end
        end
    end

    assign out_valid = valid_q[STAGES-1];
    assign {out_adrs, out_adrs_out, out_mux_en, out_wr_ctrl1, out_wr_ctrl2, out_pool_done} =
        data_q[STAGES-1];
    assign occupancy  = occ_q;
    assign done_pulse = !rst && out_xfer && out_pool_done;

endmodule

// File: tb/tb_pooling_ctrl_pipe.sv
// Drives three pipeline configurations (3/4, 1/8, 8/8 stages/addr bits) with one
// stimulus stream and checks each against an entry-position reference model.
module tb_pooling_ctrl_pipe;

    logic       clk = 1'b0;
    logic       rst, flush, in_valid, out_ready;
    logic [7:0] in_adrs, in_adrs_out;
    logic [3:0] in_ctl;

    always #5 clk = ~clk;

    logic        ir0, ov0, dn0, ir1, ov1, dn1, ir8, ov8, dn8;
    logic [3:0]  a0, ao0;
    logic [7:0]  a1, ao1, a8, ao8;
    logic [3:0]  c0, c1, c8;
    logic [1:0]  occ0;
    logic [0:0]  occ1;
    logic [3:0]  occ8;

    pooling_ctrl_pipe #(.ADDR_W(4), .STAGES(3)) u_s3 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir0),
        .in_adrs(in_adrs[3:0]), .in_adrs_out(in_adrs_out[3:0]),
        .in_mux_en(in_ctl[3]), .in_wr_ctrl1(in_ctl[2]), .in_wr_ctrl2(in_ctl[1]),
        .in_pool_done(in_ctl[0]), .out_valid(ov0), .out_ready(out_ready),
        .out_adrs(a0), .out_adrs_out(ao0), .out_mux_en(c0[3]), .out_wr_ctrl1(c0[2]),
        .out_wr_ctrl2(c0[1]), .out_pool_done(c0[0]), .occupancy(occ0), .done_pulse(dn0)
    );

    pooling_ctrl_pipe #(.ADDR_W(8), .STAGES(1)) u_s1 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir1),
        .in_adrs(in_adrs), .in_adrs_out(in_adrs_out),
        .in_mux_en(in_ctl[3]), .in_wr_ctrl1(in_ctl[2]), .in_wr_ctrl2(in_ctl[1]),
        .in_pool_done(in_ctl[0]), .out_valid(ov1), .out_ready(out_ready),
        .out_adrs(a1), .out_adrs_out(ao1), .out_mux_en(c1[3]), .out_wr_ctrl1(c1[2]),
        .out_wr_ctrl2(c1[1]), .out_pool_done(c1[0]), .occupancy(occ1), .done_pulse(dn1)
    );

    pooling_ctrl_pipe #(.ADDR_W(8), .STAGES(8)) u_s8 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir8),
        .in_adrs(in_adrs), .in_adrs_out(in_adrs_out),
        .in_mux_en(in_ctl[3]), .in_wr_ctrl1(in_ctl[2]), .in_wr_ctrl2(in_ctl[1]),
        .in_pool_done(in_ctl[0]), .out_valid(ov8), .out_ready(out_ready),
        .out_adrs(a8), .out_adrs_out(ao8), .out_mux_en(c8[3]), .out_wr_ctrl1(c8[2]),
        .out_wr_ctrl2(c8[1]), .out_pool_done(c8[0]), .occupancy(occ8), .done_pulse(dn8)
    );

    logic [19:0] obs_dat [3];
    logic        obs_ov  [3];
    logic        obs_ir  [3];
    logic        obs_dn  [3];
    logic [3:0]  obs_occ [3];

    assign obs_dat[0] = {8'h00, a0, ao0, c0};
    assign obs_dat[1] = {a1, ao1, c1};
    assign obs_dat[2] = {a8, ao8, c8};
    assign obs_ov[0] = ov0;
    assign obs_ov[1] = ov1;
    assign obs_ov[2] = ov8;
    assign obs_ir[0] = ir0;
    assign obs_ir[1] = ir1;
    assign obs_ir[2] = ir8;
    assign obs_dn[0] = dn0;
    assign obs_dn[1] = dn1;
    assign obs_dn[2] = dn8;
    assign obs_occ[0] = {2'b00, occ0};
    assign obs_occ[1] = {3'b000, occ1};
    assign obs_occ[2] = occ8;

    // Model: ordered list of in-flight entries (head first), each with its stage index.
    int          sz [3] = '{3, 1, 8};
    int          mcnt [3];
    int          mpos [3][8];
    logic [19:0] mdat [3][8];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input int k, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s dut%0d: observed %0h expected %0h", tag, k, obs, exp);
        end
    endtask

    task automatic step(input logic r, input logic fl, input logic iv, input logic ordy,
                        input logic [7:0] a, input logic [7:0] ao, input logic [3:0] ctl);
        int          s, h, n;
        logic        ov, ox, ir;
        int          np [8];
        logic [19:0] pk;
        rst = r;
        flush = fl;
        in_valid = iv;
        out_ready = ordy;
        in_adrs = a;
        in_adrs_out = ao;
        in_ctl = ctl;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            s  = sz[k];
            n  = mcnt[k];
            ov = (n > 0) && (mpos[k][0] == s - 1);
            ox = ov && ordy;
            h  = ox ? 1 : 0;
            // Each remaining entry moves one stage if the slot ahead is or becomes free.
            for (int j = h; j < n; j++) begin
                np[j] = (mpos[k][j] + 1 > s - 1) ? s - 1 : mpos[k][j] + 1;
                if (j > h && np[j] >= np[j-1]) np[j] = np[j-1] - 1;
            end
            ir = !r && !fl && ((n - h) == 0 || np[n-1] >= 1);
            chk("occupancy", k, 32'(obs_occ[k]), 32'(n));
            chk("out_valid", k, 32'(obs_ov[k]), 32'(ov));
            chk("in_ready", k, 32'(obs_ir[k]), 32'(ir));
            chk("done_pulse", k, 32'(obs_dn[k]), 32'(!r && ox && mdat[k][0][0]));
            if (ov) chk("out_payload", k, 32'(obs_dat[k]), 32'(mdat[k][0]));
            if (r || fl) begin
                mcnt[k] = 0;
            end else begin
                for (int j = h; j < n; j++) begin
                    mpos[k][j-h] = np[j];
                    mdat[k][j-h] = mdat[k][j];
                end
                n = n - h;
                if (iv && ir) begin
                    pk = (k == 0) ? {8'h00, a[3:0], ao[3:0], ctl} : {a, ao, ctl};
                    mpos[k][n] = 0;
                    mdat[k][n] = pk;
                    n++;
                end
                mcnt[k] = n;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic chk_cleared(input string tag);
        for (int k = 0; k < 3; k++) begin
            chk({tag, "_payload"}, k, 32'(obs_dat[k]), 32'h0);
            chk({tag, "_valid"}, k, 32'(obs_ov[k]), 32'h0);
            chk({tag, "_occ"}, k, 32'(obs_occ[k]), 32'h0);
        end
    endtask

    task automatic idle(input logic ordy, input int cycles);
        for (int i = 0; i < cycles; i++) step(1'b0, 1'b0, 1'b0, ordy, 8'h00, 8'h00, 4'h0);
    endtask

    initial begin
        rst = 1'b1;
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        in_adrs = '0;
        in_adrs_out = '0;
        in_ctl = '0;
        for (int k = 0; k < 3; k++) mcnt[k] = 0;
        repeat (2) @(posedge clk);
        #1;
        chk_cleared("reset");
        step(1'b1, 1'b0, 1'b1, 1'b1, 8'h55, 8'h66, 4'h1);

        // Back-to-back stream with downstream always ready.
        for (int i = 1; i <= 4; i++) step(1'b0, 1'b0, 1'b1, 1'b1, 8'(i), 8'(i + 16), 4'h0);
        idle(1'b1, 10);

        // Fill while stalled, keep offering, then drain.
        for (int i = 5; i <= 7; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 8'(i), 8'(i + 32), 4'h8);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 8'h28, 8'h29, 4'h2);
        idle(1'b1, 10);

        // Entry, bubble, entry under a five-cycle stall.
        step(1'b0, 1'b0, 1'b1, 1'b0, 8'h09, 8'h90, 4'h4);
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 4'h0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 8'h0a, 8'ha0, 4'h0);
        idle(1'b0, 5);
        idle(1'b1, 10);

        // One pool_done entry among zeros, held under stall first.
        step(1'b0, 1'b0, 1'b1, 1'b0, 8'h0b, 8'hb0, 4'h0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 8'h0c, 8'hc0, 4'h1);
        step(1'b0, 1'b0, 1'b1, 1'b0, 8'h0d, 8'hd0, 4'h0);
        idle(1'b0, 4);
        idle(1'b1, 10);

        // Flush with a pending input, then reset mid-stream.
        step(1'b0, 1'b0, 1'b1, 1'b0, 8'h0e, 8'he0, 4'h1);
        step(1'b0, 1'b0, 1'b1, 1'b0, 8'h0f, 8'hf0, 4'h0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 8'h33, 8'h44, 4'h0);
        idle(1'b1, 2);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, 1'b1, 8'(i + 64), 8'(i + 80), 4'hf);
        step(1'b1, 1'b1, 1'b1, 1'b1, 8'h77, 8'h88, 4'h1);
        chk_cleared("midrst");
        step(1'b0, 1'b0, 1'b1, 1'b1, 8'h21, 8'h12, 4'h3);
        idle(1'b1, 10);

        // Randomised traffic with occasional flush and reset.
        for (int i = 0; i < 600; i++) begin
            step(($urandom % 90) == 0, ($urandom % 40) == 0, ($urandom % 4) != 0,
                 ($urandom % 3) != 0, 8'($urandom), 8'($urandom), 4'($urandom));
        end
        idle(1'b1, 12);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
